l2_req_arbiter: RTL

- Sequences the single shared L2 access port between the instruction-cache and data-cache requesters.
- Grants one requester at a time and issues a one-cycle request pulse to the L2.
- Holds the grant until the L2 responds, then routes the response back to the owner.
- Blocking: at most one outstanding L2 request. Fixed i$ priority with a bounded d$ starvation guarantee.

---
 rtl/l2_req_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_req_arbiter.sv
// ============================================================================
// l2_req_arbiter
//
// Shares the single L2 access port between the instruction cache (i$) and
// the data cache (d$). At most one L2 request is outstanding at a time. When
// both caches ask, i$ wins, but d$ is forced through once i$ has taken
// STARVE_MAX grants in a row while d$ was waiting. An accepted request is
// sent to the L2 as a one-cycle pulse. The grant is then held until the L2
// answers, and the answer is steered back to the cache that owns the grant.
//
// Optional build macro: L2_ARB_TIMEOUT_EN
//   Defined   : a request left unanswered for TIMEOUT_CYC WAIT cycles is
//               aborted. The owner gets 32'hDEAD_BEEF and timeout_err is
//               set; it stays set until reset.
//   Undefined : WAIT lasts until the L2 answers; timeout_err is tied to 0.
//
// Ports:
//   clk, rst_n                    rising-edge clock, async active-low reset
//   ic_req_valid/ready/addr       i$ request handshake (read only)
//   ic_resp_valid/data            i$ response strobe and data
//   dc_req_valid/ready/addr/we/wdata  d$ request handshake
//   dc_resp_valid/data            d$ response strobe and data
//   l2_valid/addr/we/wdata        request pulse and latched fields to L2
//   l2_resp_valid/data            response from L2
//   timeout_err                   sticky abort flag
// ============================================================================
module l2_req_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [ADDR_W-1:0] ic_req_addr,
    output logic              ic_resp_valid,
    output logic [DATA_W-1:0] ic_resp_data,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic              dc_req_we,
    input  logic [DATA_W-1:0] dc_req_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] dc_resp_data,
    output logic              l2_valid,
    output logic [ADDR_W-1:0] l2_addr,
    output logic              l2_we,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic              l2_resp_valid,
    input  logic [DATA_W-1:0] l2_resp_data,
    output logic              timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IC   = 2'd1;
    localparam logic [1:0] OWN_DC   = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Out-of-range parameters are rejected when the design is elaborated.
    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_params
        $error("l2_req_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC 1..255");
    end

    logic [1:0]        state;
    logic [1:0]        owner;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;

    logic              dc_win;
    logic              ic_win;
    logic              resp_done;
    logic [DATA_W-1:0] resp_word;

    // Winner selection in IDLE. d$ takes the port when i$ is not asking, or
    // when the starvation count has reached its limit. The ready goes back to
    // the winner in the same cycle, so acceptance needs no extra cycle.
    always_comb begin
        dc_win = 1'b0;
        ic_win = 1'b0;
        if (state == S_IDLE) begin
            dc_win = dc_req_valid && (!ic_req_valid || (starve_cnt == STARVE_LIM));
            ic_win = ic_req_valid && !dc_win;
        end
    end

    assign ic_req_ready = ic_win;
    assign dc_req_ready = dc_win;

`ifdef L2_ARB_TIMEOUT_EN
    localparam logic [7:0]        TO_LAST    = 8'(TIMEOUT_CYC - 1);
    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

    logic [7:0] wait_cnt;
    logic       expire;
    logic       err_q;

    // Expiry is the last allowed WAIT cycle with no answer. If the L2 answers
    // in that same cycle, its data is used and no error is raised.
    always_comb begin
        expire    = (state == S_WAIT) && !l2_resp_valid && (wait_cnt == TO_LAST);
        resp_done = (state == S_WAIT) && (l2_resp_valid || expire);
        resp_word = l2_resp_valid ? l2_resp_data : ABORT_DATA;
    end

    // The WAIT counter is cleared during ISSUE, so each request starts
    // counting from zero. The error flag only clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wait_cnt <= '0;
            end else if ((state == S_WAIT) && !resp_done) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (expire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = err_q;
`else
    // Without the abort option, only a real L2 answer ends WAIT.
    always_comb begin
        resp_done = (state == S_WAIT) && l2_resp_valid;
        resp_word = l2_resp_data;
    end

    assign timeout_err = 1'b0;
`endif

    // Only the owner of the grant sees a response. Its data bus is zero
    // except in the strobe cycle, and the other requester always sees zeros.
    always_comb begin
        ic_resp_valid = resp_done && (owner == OWN_IC);
        dc_resp_valid = resp_done && (owner == OWN_DC);
        ic_resp_data  = ic_resp_valid ? resp_word : '0;
        dc_resp_data  = dc_resp_valid ? resp_word : '0;
    end

    assign l2_valid = (state == S_ISSUE);
    assign l2_addr  = lat_addr;
    assign l2_we    = lat_we;
    assign l2_wdata = lat_wdata;

    // Main sequencer. A grant in IDLE latches the request fields and the
    // owner. The starvation count goes up (saturating) only when i$ wins
    // over a waiting d$, and it clears whenever d$ is served. Any L2 response
    // seen outside WAIT is ignored, because resp_done is only set in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dc_win) begin
                        owner      <= OWN_DC;
                        lat_addr   <= dc_req_addr;
                        lat_we     <= dc_req_we;
                        lat_wdata  <= dc_req_wdata;
                        starve_cnt <= '0;
                        state      <= S_ISSUE;
                    end else if (ic_win) begin
                        owner     <= OWN_IC;
                        lat_addr  <= ic_req_addr;
                        lat_we    <= 1'b0;
                        lat_wdata <= '0;
                        if (dc_req_valid && (starve_cnt != STARVE_LIM)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                        state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (resp_done) begin
                        owner <= OWN_NONE;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    owner <= OWN_NONE;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
